// File: rtl/serdesphy_tx_serializer.sv
// TX serializer: synchronizes the host nibble strobe, queues nibbles in a small FIFO,
// 4B5B-encodes them and shifts them out MSB-first; sends IDLE when empty, PRBS7 in test mode.
module serdesphy_tx_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  PRBS_SEED  = 7'h7F
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    tx_data,
  input  logic                          tx_valid,
  input  logic                          test_mode,
  input  logic                          tx_en,
  input  logic                          pll_lock,
  input  logic                          ovf_clr,
  output logic                          txp,
  output logic                          txn,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_full,
  output logic                          ovf
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam logic [4:0]  IDLE = 5'b11111;

  typedef enum logic {ST_OFF, ST_RUN} state_t;

  state_t          state;
  logic [2:0]      tv_sync;
  logic [1:0]      tm_sync_r;
  logic            tm_sync;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [2:0]      cnt;
  logic [3:0]      sr;
  logic            prbs_sym;
  logic [6:0]      lfsr;

  logic            act;
  logic            load;
  logic            pop;
  logic            wr_req;
  logic            wr_ok;
  logic            fifo_empty;
  logic            prbs_emit;
  logic            next_bit;
  logic [4:0]      next_sym;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    logic [4:0] c;
    case (n)
      4'h0: c = 5'b11110;
      4'h1: c = 5'b01001;
      4'h2: c = 5'b10100;
      4'h3: c = 5'b10101;
      4'h4: c = 5'b01010;
      4'h5: c = 5'b01011;
      4'h6: c = 5'b01110;
      4'h7: c = 5'b01111;
      4'h8: c = 5'b10010;
      4'h9: c = 5'b10011;
      4'hA: c = 5'b10110;
      4'hB: c = 5'b10111;
      4'hC: c = 5'b11010;
      4'hD: c = 5'b11011;
      4'hE: c = 5'b11100;
      default: c = 5'b11101;
    endcase
    return c;
  endfunction

  assign tm_sync    = tm_sync_r[1];
  assign wr_req     = tv_sync[1] & ~tv_sync[2];
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));

  always_comb begin
    act       = tx_en & pll_lock;
    load      = act & ((state == ST_OFF) | (cnt == 3'd4));
    pop       = load & ~tm_sync & ~fifo_empty;
    wr_ok     = wr_req & (~fifo_full | pop);
    next_sym  = fifo_empty ? IDLE : enc4b5b(mem[rd_ptr]);
    // A PRBS symbol keeps emitting LFSR bits until its own boundary, even if test_mode drops.
    prbs_emit = act & (load ? tm_sync : ((state == ST_RUN) & prbs_sym));
    if (prbs_emit)
      next_bit = lfsr[6];
    else if (load)
      next_bit = next_sym[4];
    else
      next_bit = sr[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_sync   <= '0;
      tm_sync_r <= '0;
    end else begin
      tv_sync   <= {tv_sync[1:0], tx_valid};
      tm_sync_r <= {tm_sync_r[0], test_mode};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (wr_req & ~wr_ok)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !act) begin
      state    <= ST_OFF;
      cnt      <= '0;
      sr       <= '0;
      prbs_sym <= 1'b0;
      txp      <= 1'b0;
      txn      <= 1'b0;
    end else if (load) begin
      state    <= ST_RUN;
      cnt      <= '0;
      sr       <= next_sym[3:0];
      prbs_sym <= tm_sync;
      txp      <= next_bit;
      txn      <= ~next_bit;
    end else begin
      cnt      <= cnt + 3'd1;
      sr       <= {sr[2:0], 1'b0};
      txp      <= next_bit;
      txn      <= ~next_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= PRBS_SEED;
    else if (prbs_emit)
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    else if (!tm_sync || state == ST_OFF)
      lfsr <= PRBS_SEED;
  end

endmodule
